// File: rtl/dmem_store_unit_pkg.sv
// xg_store_pkg: shared definitions for the data-memory store path.
//   LANES              : byte lanes on the 32-bit data bus
//   F3_SB/F3_SH/F3_SW  : funct3 encodings of the supported stores
//   state_t            : store unit FSM states
package xg_store_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_store_unit_lane_align.sv
// store_lane_align: combinational byte-lane steering for one store.
//   addr_lo [1:0]  in  : low address bits (byte offset within the word)
//   funct3  [2:0]  in  : store size (SB/SH/SW)
//   data    [DW]   in  : right-justified store data
//   wdata   [DW]   out : data replicated onto every lane it may occupy
//   wstrb   [4]    out : byte enables for the addressed lanes
//   legal          out : store is naturally aligned and of a supported size
module store_lane_align
  import xg_store_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  input  logic [DW-1:0]    data,
  output logic [DW-1:0]    wdata,
  output logic [LANES-1:0] wstrb,
  output logic             legal
);

  always_comb begin
    wdata = '0;
    wstrb = '0;
    legal = 1'b0;
    case (funct3)
      F3_SB: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
        legal = 1'b1;
      end
      F3_SH: begin
        wdata = {2{data[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        legal = ~addr_lo[0];
      end
      F3_SW: begin
        wdata = data;
        wstrb = 4'b1111;
        legal = (addr_lo == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_store_unit.sv
// dmem_store_unit: accepts one SB/SH/SW store and issues it to data memory
// over a valid/ready write handshake, one store in flight at a time.
//   clk, rstn                : clock, asynchronous active-low reset
//   req_valid/req_ready      : store request handshake from the MEM stage
//   req_addr/data/funct3     : byte address, right-justified data, size
//   mem_valid/mem_ready      : write handshake to data memory
//   mem_addr/wdata/wstrb     : word address, lane-steered data, byte enables
//   done                     : one-cycle pulse, store committed
//   misalign                 : one-cycle pulse, store rejected
//   busy                     : unit is not idle
module dmem_store_unit
  import xg_store_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_data,
  input  logic [2:0]       req_funct3,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic [LANES-1:0] mem_wstrb,
  output logic             done,
  output logic             misalign,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [AW-1:0]    addr_p1;
  logic [DW-1:0]    wdata_p1;
  logic [LANES-1:0] wstrb_p1;

  logic [DW-1:0]    al_wdata;
  logic [LANES-1:0] al_wstrb;
  logic             al_legal;
  logic             accept;

  store_lane_align #(.DW(DW)) u_align (
    .addr_lo (req_addr[1:0]),
    .funct3  (req_funct3),
    .data    (req_data),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .legal   (al_legal)
  );

  assign accept = req_valid && (state == IDLE);

  // ---- stage p1: request capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept && al_legal) begin
      addr_p1  <= {req_addr[AW-1:2], 2'b00};
      wdata_p1 <= al_wdata;
      wstrb_p1 <= al_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory-side outputs are forced to zero outside ISSUE so the data
  // registers need no reset and a reset mid-store clears them at once.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    done      = 1'b0;
    misalign  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = al_legal ? ISSUE : ERR;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        mem_addr  = addr_p1;
        mem_wdata = wdata_p1;
        mem_wstrb = wstrb_p1;
        if (mem_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        misalign  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_store_unit.sv
module tb_dmem_store_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_funct3 = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        misalign;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic both_seen = 1'b0;

  dmem_store_unit #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_funct3 (req_funct3),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .done       (done),
    .misalign   (misalign),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (done && misalign) both_seen <= 1'b1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    int          stall;
    logic        legal;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference lane model: lane i is enabled when it falls inside the
  // accessed bytes; every lane carries data byte (i mod size).
  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3,
                                output logic [3:0] s, output logic [31:0] w);
    int size;
    int off;
    size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    off  = (f3 == 3'b000) ? int'(a[1:0]) : (f3 == 3'b001) ? int'({a[1], 1'b0}) : 0;
    for (int i = 0; i < 4; i++) begin
      s[i] = (i >= off) && (i < off + size);
      w[8*i +: 8] = d[8*(i % size) +: 8];
    end
  endfunction

  // Called at a falling edge with the unit idle.
  task automatic run_store(input vec_t v);
    int d0;
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    req_data   = v.data;
    req_funct3 = v.f3;
    mem_ready  = 1'b0;
    tick();
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_data   = $urandom;
    req_funct3 = 3'($urandom);
    d0 = done_cnt;
    if (v.legal) begin
      for (int k = 0; k <= v.stall; k++) begin
        chk1("mem_valid", mem_valid, 1'b1);
        chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("mem_wdata", mem_wdata, v.wdata);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.strb});
        chk1("req_ready_busy", req_ready, 1'b0);
        chk1("done_early", done, 1'b0);
        mem_ready = (k == v.stall);
        tick();
      end
      mem_ready = 1'b0;
      chk1("done_pulse", done, 1'b1);
      chk1("mem_valid_done", mem_valid, 1'b0);
      chk1("misalign_legal", misalign, 1'b0);
      tick();
      chk1("done_one_cycle", done, 1'b0);
      chk1("req_ready_back", req_ready, 1'b1);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
    end else begin
      chk1("misalign_pulse", misalign, 1'b1);
      chk1("mem_valid_err", mem_valid, 1'b0);
      chk1("done_err", done, 1'b0);
      chk1("req_ready_err", req_ready, 1'b0);
      tick();
      chk1("misalign_one_cycle", misalign, 1'b0);
      chk1("mem_valid_after_err", mem_valid, 1'b0);
      chk1("req_ready_after_err", req_ready, 1'b1);
      chk("done_count_err", 32'(done_cnt - d0), 32'd0);
    end
  endtask

  initial begin
    vec_t rv;
    int   d0;

    vecs[0] = '{32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0, 1'b1, 4'b1000, 32'hDDDD_DDDD};
    vecs[1] = '{32'h0000_2002, 32'h0000_1234, 3'b001, 3, 1'b1, 4'b1100, 32'h1234_1234};
    vecs[2] = '{32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 0, 1'b1, 4'b1111, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_3001, 32'hDEAD_BEEF, 3'b010, 0, 1'b0, 4'b0000, 32'h0};
    vecs[4] = '{32'h0000_4000, 32'h1122_3344, 3'b011, 0, 1'b0, 4'b0000, 32'h0};
    vecs[5] = '{32'h0000_2001, 32'h5555_AAAA, 3'b001, 0, 1'b0, 4'b0000, 32'h0};
    vecs[6] = '{32'h0000_5000, 32'h0000_00A5, 3'b000, 1, 1'b1, 4'b0001, 32'hA5A5_A5A5};
    vecs[7] = '{32'h0000_6000, 32'hCAFE_F00D, 3'b001, 2, 1'b1, 4'b0011, 32'hF00D_F00D};
    vecs[8] = '{32'h0000_7002, 32'h1234_5678, 3'b000, 0, 1'b1, 4'b0100, 32'h7878_7878};
    vecs[9] = '{32'h0000_8000, 32'h0F0F_0F0F, 3'b111, 0, 1'b0, 4'b0000, 32'h0};

    // Reset state
    #1 rstn = 1'b0;
    tick();
    tick();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_misalign", misalign, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    tick();

    // mem_ready with no write outstanding does nothing
    mem_ready = 1'b1;
    tick();
    chk1("stray_ready_busy", busy, 1'b0);
    chk1("stray_ready_done", done, 1'b0);
    chk1("stray_ready_mem_valid", mem_valid, 1'b0);
    mem_ready = 1'b0;

    for (int i = 0; i < 10; i++) run_store(vecs[i]);

    // req_valid held through ISSUE is not re-accepted
    req_valid  = 1'b1;
    req_addr   = 32'h0000_A001;
    req_data   = 32'h0000_0077;
    req_funct3 = 3'b000;
    d0 = done_cnt;
    tick();
    for (int k = 0; k <= 2; k++) begin
      chk1("hold_req_ready", req_ready, 1'b0);
      chk1("hold_mem_valid", mem_valid, 1'b1);
      chk("hold_mem_addr", mem_addr, 32'h0000_A000);
      chk("hold_mem_wstrb", {28'd0, mem_wstrb}, 32'h2);
      chk("hold_mem_wdata", mem_wdata, 32'h7777_7777);
      mem_ready = (k == 2);
      tick();
    end
    mem_ready = 1'b0;
    chk1("hold_done", done, 1'b1);
    chk1("hold_req_ready_done", req_ready, 1'b0);
    tick();
    chk1("hold_req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b0;
    chk("hold_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset during ISSUE aborts the store
    req_valid  = 1'b1;
    req_addr   = 32'h0000_9000;
    req_data   = 32'h0BAD_F00D;
    req_funct3 = 3'b010;
    mem_ready  = 1'b0;
    tick();
    req_valid = 1'b0;
    chk1("abort_mem_valid_pre", mem_valid, 1'b1);
    d0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    chk1("abort_mem_valid", mem_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_req_ready", req_ready, 1'b1);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_misalign", misalign, 1'b0);
    mem_ready = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    chk1("abort_idle_busy", busy, 1'b0);
    chk1("abort_idle_done", done, 1'b0);
    mem_ready = 1'b0;
    chk("abort_done_count", 32'(done_cnt - d0), 32'd0);
    rv = '{32'h0000_B001, 32'h0000_00C3, 3'b000, 1, 1'b1, 4'b0010, 32'hC3C3_C3C3};
    run_store(rv);

    // Random legal stores with random memory stalls
    for (int n = 0; n < 100; n++) begin
      rv.f3   = 3'($urandom_range(0, 2));
      rv.addr = $urandom;
      rv.data = $urandom;
      if (rv.f3 == 3'b001) rv.addr[0] = 1'b0;
      if (rv.f3 == 3'b010) rv.addr[1:0] = 2'b00;
      rv.stall = $urandom_range(0, 3);
      rv.legal = 1'b1;
      model(rv.addr, rv.data, rv.f3, rv.strb, rv.wdata);
      run_store(rv);
    end

    chk1("done_misalign_exclusive", both_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
